// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Bimodal 2-bit counter direction predictor with direct-mapped BTB;
//            optional gshare indexing via `BRANCH_PREDICTOR_GSHARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int RegWidth = 32,
  parameter int Entries  = 64
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iFetchValid,
  input  logic [RegWidth-1:0] iFetchPC,
  output logic                oPredValid,
  output logic                oPredTaken,
  output logic [RegWidth-1:0] oPredTarget,
  output logic                oReady,
  input  logic                iUpdValid,
  input  logic [RegWidth-1:0] iUpdPC,
  input  logic                iUpdTaken,
  input  logic [RegWidth-1:0] iUpdTarget,
  input  logic                iUpdPredTaken,
  output logic                oMispredict
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagW = RegWidth - IdxW - 2;
  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(Entries - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [IdxW-1:0]     r_walk;
  logic                w_run;

  logic [1:0]          r_ctr        [Entries];
  logic                r_btb_valid  [Entries];
  logic [TagW-1:0]     r_btb_tag    [Entries];
  logic [RegWidth-1:0] r_btb_target [Entries];

  logic [IdxW-1:0]     w_fetch_idx;
  logic [TagW-1:0]     w_fetch_tag;
  logic [IdxW-1:0]     w_upd_idx;
  logic [TagW-1:0]     w_upd_tag;
  logic [IdxW-1:0]     w_fetch_ctr_idx;
  logic [IdxW-1:0]     w_upd_ctr_idx;
  logic [1:0]          w_upd_ctr;
  logic [1:0]          w_ctr_nxt;
  logic                w_hit;
  logic                w_unused_lsb;

  assign w_fetch_idx  = iFetchPC[IdxW+1:2];
  assign w_fetch_tag  = iFetchPC[RegWidth-1:IdxW+2];
  assign w_upd_idx    = iUpdPC[IdxW+1:2];
  assign w_upd_tag    = iUpdPC[RegWidth-1:IdxW+2];
  assign w_unused_lsb = ^{iFetchPC[1:0], iUpdPC[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IdxW-1:0] r_ghr;

  // History is only meaningful once the table is live, so INIT holds it at 0.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_ghr <= '0;
    end else if (!w_run) begin
      r_ghr <= '0;
    end else if (iUpdValid) begin
      r_ghr <= {r_ghr[IdxW-2:0], iUpdTaken};
    end
  end

  assign w_fetch_ctr_idx = w_fetch_idx ^ r_ghr;
  assign w_upd_ctr_idx   = w_upd_idx ^ r_ghr;
`else
  assign w_fetch_ctr_idx = w_fetch_idx;
  assign w_upd_ctr_idx   = w_upd_idx;
`endif

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_INIT;
      r_walk  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_walk <= r_walk + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_walk == LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_run  = 1'b0;
    oReady = 1'b0;
    if (r_state == ST_RUN) begin
      w_run  = 1'b1;
      oReady = 1'b1;
    end
  end

  assign w_hit = r_ctr[w_fetch_ctr_idx][1] & r_btb_valid[w_fetch_idx] &
                 (r_btb_tag[w_fetch_idx] == w_fetch_tag);

  assign w_upd_ctr = r_ctr[w_upd_ctr_idx];

  always_comb begin
    w_ctr_nxt = w_upd_ctr;
    if (iUpdTaken) begin
      if (w_upd_ctr != 2'b11) w_ctr_nxt = w_upd_ctr + 2'd1;
    end else begin
      if (w_upd_ctr != 2'b00) w_ctr_nxt = w_upd_ctr - 2'd1;
    end
  end

  // Table storage has no reset: the INIT walk rewrites every entry.
  always_ff @(posedge iClk) begin
    if (!w_run) begin
      r_ctr[r_walk]       <= 2'b01;
      r_btb_valid[r_walk] <= 1'b0;
    end else if (iUpdValid) begin
      r_ctr[w_upd_ctr_idx] <= w_ctr_nxt;
      if (iUpdTaken) begin
        r_btb_valid[w_upd_idx]  <= 1'b1;
        r_btb_tag[w_upd_idx]    <= w_upd_tag;
        r_btb_target[w_upd_idx] <= iUpdTarget;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPredValid  <= 1'b0;
      oPredTaken  <= 1'b0;
      oPredTarget <= '0;
      oMispredict <= 1'b0;
    end else begin
      oPredValid  <= w_run & iFetchValid;
      oPredTaken  <= w_run & iFetchValid & w_hit;
      oPredTarget <= (w_run & iFetchValid & w_hit) ? r_btb_target[w_fetch_idx] : '0;
      oMispredict <= w_run & iUpdValid & (iUpdPredTaken != iUpdTaken);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed plus randomized bench for branch_predictor against a
//            per-entry behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int RW = 32;
  localparam int E  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          iRst_n;
  logic          iFetchValid;
  logic [RW-1:0] iFetchPC;
  logic          oPredValid;
  logic          oPredTaken;
  logic [RW-1:0] oPredTarget;
  logic          oReady;
  logic          iUpdValid;
  logic [RW-1:0] iUpdPC;
  logic          iUpdTaken;
  logic [RW-1:0] iUpdTarget;
  logic          iUpdPredTaken;
  logic          oMispredict;

  always #5 clk = ~clk;

  branch_predictor #(.RegWidth(RW), .Entries(E)) dut (
    .iClk          (clk),
    .iRst_n        (iRst_n),
    .iFetchValid   (iFetchValid),
    .iFetchPC      (iFetchPC),
    .oPredValid    (oPredValid),
    .oPredTaken    (oPredTaken),
    .oPredTarget   (oPredTarget),
    .oReady        (oReady),
    .iUpdValid     (iUpdValid),
    .iUpdPC        (iUpdPC),
    .iUpdTaken     (iUpdTaken),
    .iUpdTarget    (iUpdTarget),
    .iUpdPredTaken (iUpdPredTaken),
    .oMispredict   (oMispredict)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counter value 0..3 per index, BTB remembers the full branch PC.
  int          m_ctr [E];
  bit          m_val [E];
  logic [31:0] m_pc  [E];
  logic [31:0] m_tgt [E];
  int          m_ghr;
  int          m_init;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % E);
  endfunction

  function automatic int ctr_idx(input logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return pc_idx(pc) ^ m_ghr;
`else
    return pc_idx(pc);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < E; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 1'b0;
      m_pc[i]  = '0;
      m_tgt[i] = '0;
    end
    m_ghr = 0;
  endtask

  task automatic cycle(input bit fv, input logic [31:0] fpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit upt);
    bit          run;
    bit          e_valid;
    bit          e_taken;
    bit          e_mis;
    logic [31:0] e_tgt;
    int          ci;
    int          bi;
    iFetchValid   = fv;
    iFetchPC      = fpc;
    iUpdValid     = uv;
    iUpdPC        = upc;
    iUpdTaken     = ut;
    iUpdTarget    = utgt;
    iUpdPredTaken = upt;
    @(posedge clk);
    #1;
    run     = (m_init >= E);
    e_valid = fv && run;
    ci      = ctr_idx(fpc);
    bi      = pc_idx(fpc);
    e_taken = e_valid && (m_ctr[ci] >= 2) && m_val[bi] &&
              ((m_pc[bi] >> (IW + 2)) == (fpc >> (IW + 2)));
    e_tgt   = e_taken ? m_tgt[bi] : 32'h0;
    e_mis   = run && uv && (upt != ut);
    if (run && uv) begin
      ci = ctr_idx(upc);
      if (ut) m_ctr[ci] = (m_ctr[ci] == 3) ? 3 : m_ctr[ci] + 1;
      else    m_ctr[ci] = (m_ctr[ci] == 0) ? 0 : m_ctr[ci] - 1;
      if (ut) begin
        bi        = pc_idx(upc);
        m_val[bi] = 1'b1;
        m_pc[bi]  = upc;
        m_tgt[bi] = utgt;
      end
      m_ghr = ((m_ghr << 1) | int'(ut)) % E;
    end
    if (!run) begin
      m_init++;
      if (m_init == E) model_clear();
    end
    check("pred_valid", 32'(oPredValid), 32'(e_valid));
    check("pred_taken", 32'(oPredTaken), 32'(e_taken));
    check("pred_target", oPredTarget, e_tgt);
    check("mispredict", 32'(oMispredict), 32'(e_mis));
    check("ready", 32'(oReady), 32'(m_init >= E));
  endtask

  task automatic fetch(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit pt);
    cycle(1'b0, 32'h0, 1'b1, pc, t, tgt, pt);
  endtask

  task automatic do_reset();
    iRst_n      = 1'b0;
    iFetchValid = 1'b0;
    iUpdValid   = 1'b0;
    #1;
    check("rst_pred_valid", 32'(oPredValid), 32'h0);
    check("rst_pred_taken", 32'(oPredTaken), 32'h0);
    check("rst_pred_target", oPredTarget, 32'h0);
    check("rst_ready", 32'(oReady), 32'h0);
    check("rst_mispredict", 32'(oMispredict), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    iRst_n = 1'b1;
    m_init = 0;
    m_ghr  = 0;
  endtask

  initial begin
    iRst_n = 1'b1;
    iFetchValid = 1'b0; iFetchPC = '0; iUpdValid = 1'b0; iUpdPC = '0;
    iUpdTaken = 1'b0; iUpdTarget = '0; iUpdPredTaken = 1'b0;
    model_clear();
    m_init = 0;
    #2;
    do_reset();

    // Init walk with fetches every cycle
    for (int i = 0; i < E; i++) fetch(32'h100);
    check("init_done_ready", 32'(oReady), 32'h1);
    fetch(32'h100);
    check("first_pred_taken", 32'(oPredTaken), 32'h0);
    check("first_pred_target", oPredTarget, 32'h0);

    // Training and hysteresis
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    fetch(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("trained_taken", 32'(oPredTaken), 32'h1);
    check("trained_target", oPredTarget, 32'h200);
`endif
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    fetch(32'h100);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    fetch(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("two_nt_not_taken", 32'(oPredTaken), 32'h0);
`endif

    // Saturation at both ends
    repeat (5) upd(32'h100, 1'b1, 32'h200, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    fetch(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("sat_hi_taken", 32'(oPredTaken), 32'h1);
`endif
    repeat (5) upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    fetch(32'h100);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("sat_lo_not_taken", 32'(oPredTaken), 32'h0);
`endif

    // Alias shares the counter but fails the BTB tag
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b1);
    fetch(32'h100 + 32'(4 * E));
    check("alias_taken", 32'(oPredTaken), 32'h0);
    check("alias_target", oPredTarget, 32'h0);

    // Mid-RUN reset with live outputs
    cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    do_reset();
    for (int i = 0; i < E; i++) cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0);

    // Read-old on same-cycle fetch/update, then mispredict pulse shape
    cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    check("readold_taken", 32'(oPredTaken), 32'h0);
    check("readold_mispredict", 32'(oMispredict), 32'h1);
    upd(32'h100, 1'b1, 32'h200, 1'b1);
    check("agree_no_mispredict", 32'(oMispredict), 32'h0);

    // Randomized traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] fpc;
      logic [31:0] upc;
      fpc = (32'($urandom_range(0, 2)) << (IW + 2)) | (32'($urandom_range(0, 7)) << 2) |
            32'($urandom_range(0, 3));
      upc = (32'($urandom_range(0, 2)) << (IW + 2)) | (32'($urandom_range(0, 7)) << 2) |
            32'($urandom_range(0, 3));
      if (n == 1000) begin
        do_reset();
      end
      cycle(1'($urandom), fpc, 1'($urandom), upc, 1'($urandom), $urandom, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage. It predicts a conditional branch's direction and target from the fetch PC. It is trained by the resolved outcome that the execute-stage branch comparator produces on `oBrTrue`. The block holds a table of 2-bit saturating counters and a direct-mapped branch target buffer (BTB). It also flags mispredictions back to the pipeline control.

## Interface
Parameters:
- `RegWidth`, 32: PC and target width.
- `Entries`, 64: counter/BTB entries; power of two, ≥4. `IdxW = log2(Entries)`; `TagW = RegWidth-IdxW-2`.

Ports:
- `iClk` in 1: clock; all state updates on rising edge.
- `iRst_n` in 1: reset; asynchronous, active-low.
- `iFetchValid` in 1: fetch lookup request this cycle.
- `iFetchPC` in RegWidth: PC to predict.
- `oPredValid` out 1: prediction outputs valid (registered).
- `oPredTaken` out 1: predicted taken.
- `oPredTarget` out RegWidth: predicted target; 0 when `oPredTaken`=0.
- `oReady` out 1: table initialised; predictions and updates accepted.
- `iUpdValid` in 1: resolved branch from execute.
- `iUpdPC` in RegWidth: PC of resolved branch.
- `iUpdTaken` in 1: actual outcome (driven from the comparator's `oBrTrue`).
- `iUpdTarget` in RegWidth: actual taken target.
- `iUpdPredTaken` in 1: direction that was predicted for this branch.
- `oMispredict` out 1: registered pulse, direction mispredicted.

## Operation
- FSM states are INIT and RUN. Reset forces INIT with walk index 0.
- INIT:
  - Writes entry [idx] each cycle: counter=01 (weakly not-taken), BTB valid=0.
  - After entry Entries-1 is written, moves to RUN. INIT therefore lasts exactly `Entries` cycles after reset release.
  - `oReady`=0. Fetch requests yield `oPredValid`=0. Updates are dropped and `oMispredict` stays 0.
- RUN:
  - `oReady`=1.
  - Lookup index = `iFetchPC[IdxW+1:2]`; tag = `iFetchPC[RegWidth-1:IdxW+2]`.
  - Predict taken iff counter[1]=1 AND BTB valid AND tag matches. Then `oPredTarget` = stored target; otherwise 0.
- Update (RUN, `iUpdValid`=1):
  - Counter at the update index moves +1 if taken, −1 if not taken. It saturates at 11 and 00, with no wrap.
  - If taken, the BTB entry is written: valid=1, tag, `iUpdTarget`. Not-taken leaves the BTB unchanged.
- `oMispredict` = `iUpdValid & (iUpdPredTaken != iUpdTaken)` from RUN, registered.
- Counters are tagless, so aliasing PCs share a counter. The BTB tag rejects a wrong target.
- PC bits [1:0] are ignored.

## Timing
- Reset values: `oPredValid`=0, `oPredTaken`=0, `oPredTarget`=0, `oReady`=0, `oMispredict`=0; FSM=INIT; walk index=0.
- Prediction latency is 1 cycle. A request sampled at edge N has its result valid after edge N, for one cycle. `oPredValid` follows `iFetchValid` delayed by one cycle.
- Update takes effect at the edge it is sampled. A lookup sampled at the same edge to the same index returns the pre-update state (read-old). A lookup at the next edge sees the new state.
- `oMispredict` is a 1-cycle pulse on the edge after the update is sampled.
- `oReady` rises on the edge that completes the last INIT write.
- Async reset assertion mid-RUN or mid-INIT:
  - Outputs clear immediately.
  - The walk restarts at 0 after release.
  - Table contents are not trusted until INIT completes.
- Simultaneous fetch and update to different indices both proceed with no stall. The block never back-pressures.

## Configuration
- `BRANCH_PREDICTOR_GSHARE_EN` defined:
  - Adds an IdxW-bit global history register (GHR), reset to 0 and cleared during INIT.
  - Counter index = PC index bits XOR GHR, for both lookup and update. The BTB is still indexed by PC bits only.
  - On each RUN update the GHR shifts left and inserts `iUpdTaken` at bit 0.
- Undefined: no GHR; counter index = PC bits only (bimodal).

## Test plan
- Reset release, `Entries`=64, fetch every cycle:
  - `oReady`=0 and `oPredValid`=0 for 64 cycles.
  - `oReady`=1 on cycle 64.
  - First prediction: taken=0, target=0.
- Train PC 0x100 taken, target 0x200, twice:
  - Counter 01→10→11.
  - Fetch 0x100 → taken=1, target=0x200.
  - One not-taken update → still taken (10). A second → not taken (01).
- Saturation:
  - Five taken updates then one not-taken on 0x100 → still predicts taken.
  - Five not-taken updates → counter 00; then one taken → not taken.
- Alias PC 0x100+4·Entries (0x200 for 64 entries) after training 0x100 taken → tag mismatch → taken=0, target=0.
- Read-old and mispredict:
  - Update 0x100 taken (`iUpdPredTaken`=0), with same-cycle fetch of 0x100 on an untrained table → prediction not taken.
  - `oMispredict` pulses 1 on the next cycle.
  - Update with `iUpdPredTaken`=`iUpdTaken` → no pulse.
- `iRst_n` pulsed low mid-RUN after training → outputs 0 at once; INIT re-runs; 0x100 then predicts not taken. With GSHARE_EN, GHR=0 after reset.
